// File: rtl/perceptron_pkg.sv
// Shared perceptron definitions: default dimensions, loader state encoding and
// the per-step sample bundle handed to the trainer.
package perceptron_pkg;

    localparam int N_SAMPLES_DEF = 3;
    localparam int DIM_DEF       = 2;
    localparam int FEAT_W_DEF    = 4;
    localparam int EPOCHS_DEF    = 4;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LOAD   = 3'd1,
        LD_FULL   = 3'd2,
        LD_STREAM = 3'd3,
        LD_DONE   = 3'd4
    } loader_state_e;

    typedef struct packed {
        logic [DIM_DEF-1:0][FEAT_W_DEF-1:0] x;
        logic                               y;
    } sample_t;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == LD_LOAD) || (st == LD_STREAM);
    endfunction

endpackage

// File: rtl/perceptron_sample_buffer.sv
// Training-set register file: one synchronous feature/label write port and one
// combinational read port addressed by sample index.
module perceptron_sample_buffer
    import perceptron_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int DIM       = DIM_DEF,
    parameter int FEAT_W    = FEAT_W_DEF,
    parameter int IDX_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    parameter int F_W       = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_wr_sample,
    input  logic [F_W-1:0]        i_wr_feat,
    input  logic [FEAT_W-1:0]     i_wr_data,
    input  logic                  i_label_we,
    input  logic                  i_label,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DIM*FEAT_W-1:0] o_rd_x,
    output logic                  o_rd_y
);

    logic [DIM*FEAT_W-1:0] r_x [N_SAMPLES];
    logic                  r_y [N_SAMPLES];

    // Contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_x[i_wr_sample][i_wr_feat*FEAT_W +: FEAT_W] <= i_wr_data;
        end
        if (i_label_we) begin
            r_y[i_wr_sample] <= i_label;
        end
    end

    always_comb begin
        o_rd_x = '0;
        o_rd_y = 1'b0;
        if (int'(i_rd_idx) < N_SAMPLES) begin
            o_rd_x = r_x[i_rd_idx];
            o_rd_y = r_y[i_rd_idx];
        end else begin
            o_rd_x = '0;
            o_rd_y = 1'b0;
        end
    end

endmodule

// File: rtl/perceptron_sample_loader.sv
// Byte-serial sample loader and multi-epoch streamer for the perceptron trainer.
// Optional feature macro: SAMPLE_REPLAY_EN (EPOCHS passes per start; else one pass).
module perceptron_sample_loader
    import perceptron_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int DIM       = DIM_DEF,
    parameter int FEAT_W    = FEAT_W_DEF,
    parameter int EPOCHS    = EPOCHS_DEF,
    localparam int IDX_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    localparam int EP_W     = (EPOCHS > 1) ? $clog2(EPOCHS) : 1,
    localparam int F_W      = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIM*FEAT_W-1:0] out_x,
    output logic                  out_y,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic [EP_W-1:0]       out_epoch,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam logic [2:0] S_IDLE   = LD_IDLE;
    localparam logic [2:0] S_LOAD   = LD_LOAD;
    localparam logic [2:0] S_FULL   = LD_FULL;
    localparam logic [2:0] S_STREAM = LD_STREAM;
    localparam logic [2:0] S_DONE   = LD_DONE;

    logic [2:0]            r_state, w_state_nxt, w_load_nxt;
    logic [F_W-1:0]        r_f, w_cur_f;
    logic [IDX_W-1:0]      r_s, w_cur_s, r_idx, w_nxt_idx, w_rd_idx;
    logic [EP_W-1:0]       r_epoch, w_nxt_epoch;
    logic                  r_in_ready, r_out_valid, r_out_y, r_out_last;
    logic                  r_busy, r_done, r_load_err;
    logic [DIM*FEAT_W-1:0] r_out_x, w_rd_x;
    logic                  w_rd_y, w_accept, w_xfer, w_f_last, w_s_last;
    logic                  w_idx_last, w_ep_last, w_stream_go, w_unused_in;

    assign w_accept    = in_valid && r_in_ready;
    assign w_xfer      = r_out_valid && out_ready;
    // IDLE and DONE restart the fill at sample 0, feature 0.
    assign w_cur_f     = (r_state == S_LOAD) ? r_f : '0;
    assign w_cur_s     = (r_state == S_LOAD) ? r_s : '0;
    assign w_f_last    = (w_cur_f == F_W'(DIM - 1));
    assign w_s_last    = (w_cur_s == IDX_W'(N_SAMPLES - 1));
    assign w_idx_last  = (r_idx == IDX_W'(N_SAMPLES - 1));
    assign w_nxt_idx   = w_idx_last ? '0 : r_idx + IDX_W'(1);
    assign w_nxt_epoch = w_idx_last ? r_epoch + EP_W'(1) : r_epoch;
    assign w_stream_go = start && ((r_state == S_FULL) || ((r_state == S_DONE) && !w_accept));
    assign w_rd_idx    = w_stream_go ? '0 : w_nxt_idx;
    assign w_load_nxt  = (w_f_last && w_s_last) ? S_FULL : S_LOAD;
    assign w_unused_in = ^in_data;

`ifdef SAMPLE_REPLAY_EN
    assign w_ep_last = (r_epoch == EP_W'(EPOCHS - 1));
    assign out_epoch = r_epoch;
`else
    assign w_ep_last = 1'b1;
    assign out_epoch = '0;
`endif

    perceptron_sample_buffer #(
        .N_SAMPLES (N_SAMPLES),
        .DIM       (DIM),
        .FEAT_W    (FEAT_W)
    ) u_buffer (
        .clk         (clk),
        .i_we        (w_accept),
        .i_wr_sample (w_cur_s),
        .i_wr_feat   (w_cur_f),
        .i_wr_data   (in_data[FEAT_W-1:0]),
        .i_label_we  (w_accept && w_f_last),
        .i_label     (in_data[7]),
        .i_rd_idx    (w_rd_idx),
        .o_rd_x      (w_rd_x),
        .o_rd_y      (w_rd_y)
    );

    // Next-state selection; a byte arriving in DONE wins over a coincident start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = w_accept ? w_load_nxt : S_IDLE;
            S_LOAD:   w_state_nxt = w_accept ? w_load_nxt : S_LOAD;
            S_FULL:   w_state_nxt = start ? S_STREAM : S_FULL;
            S_STREAM: w_state_nxt = (w_xfer && w_idx_last && w_ep_last) ? S_DONE : S_STREAM;
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_load_nxt;
                end else if (start) begin
                    w_state_nxt = S_STREAM;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_f         <= '0;
            r_s         <= '0;
            r_idx       <= '0;
            r_epoch     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD) || (w_state_nxt == S_DONE);
            r_busy     <= is_busy(w_state_nxt);
            r_done     <= (w_state_nxt == S_DONE);
            if (start && ((r_state == S_IDLE) || (r_state == S_LOAD))) begin
                r_load_err <= 1'b1;
            end
            if (w_accept) begin
                r_f <= w_f_last ? '0 : w_cur_f + F_W'(1);
                r_s <= !w_f_last ? w_cur_s : (w_s_last ? '0 : w_cur_s + IDX_W'(1));
            end
            // Presented sample only changes on start or an accepted transfer.
            if (w_stream_go) begin
                r_idx       <= '0;
                r_epoch     <= '0;
                r_out_valid <= 1'b1;
                r_out_x     <= w_rd_x;
                r_out_y     <= w_rd_y;
                r_out_last  <= (N_SAMPLES == 1);
            end else if (w_xfer) begin
                if (w_idx_last && w_ep_last) begin
                    r_out_valid <= 1'b0;
                end else begin
                    r_idx      <= w_nxt_idx;
                    r_epoch    <= w_nxt_epoch;
                    r_out_x    <= w_rd_x;
                    r_out_y    <= w_rd_y;
                    r_out_last <= (w_nxt_idx == IDX_W'(N_SAMPLES - 1));
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_idx   = r_idx;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Directed-vector bench for perceptron_sample_loader; honours SAMPLE_REPLAY_EN.
module tb_perceptron_sample_loader;

`ifdef SAMPLE_REPLAY_EN
    localparam int EP = 4;
`else
    localparam int EP = 1;
`endif
    localparam int RUN = 3 * EP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       start = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_x;
    logic       out_y;
    logic [1:0] out_idx;
    logic       out_last;
    logic [1:0] out_epoch;
    logic       busy;
    logic       done;
    logic       load_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_xa [3] = '{8'h32, 8'h54, 8'h21};
    logic       exp_ya [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] exp_xb [3] = '{8'h17, 8'h65, 8'h30};
    logic       exp_yb [3] = '{1'b0, 1'b1, 1'b1};

    perceptron_sample_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_epoch (out_epoch),
        .busy      (busy),
        .done      (done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] obs;
        rst = 1'b1;
        tick();
        tick();
        obs = {in_ready, out_valid, out_x, out_y, out_idx, out_last, busy, done, load_err};
        tests++;
        if (obs !== 16'h0000 || out_epoch !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs got %h epoch %0d required 0000 epoch 0", obs, out_epoch);
        end
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset in_ready=%b busy=%b done=%b required 1 0 0", in_ready, busy, done);
        end
    endtask

    task automatic test_load_err;
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        pulse_start();
        tests++;
        if (load_err !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_start err=%b busy=%b in_ready=%b out_valid=%b required 1 1 1 0",
                     load_err, busy, in_ready, out_valid);
        end
        send_byte(8'h85);
        send_byte(8'h01);
        send_byte(8'h82);
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_err !== 1'b1) begin
            fails++;
            $display("FAIL full_after_load in_ready=%b busy=%b done=%b err=%b required 0 0 0 1",
                     in_ready, busy, done, load_err);
        end
    endtask

    task automatic test_stream;
        logic [14:0] obs, expv;
        out_ready = 1'b1;
        pulse_start();
        for (int n = 0; n < RUN; n++) begin
            obs  = {out_valid, out_x, out_y, out_idx, out_last, out_epoch};
            expv = {1'b1, exp_xa[n % 3], exp_ya[n % 3], 2'(n % 3), (n % 3) == 2, 2'(n / 3)};
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL stream[%0d] v/x/y/idx/last/ep got %h required %h", n, obs, expv);
            end
            tick();
        end
        tests++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stream_done done=%b valid=%b busy=%b in_ready=%b required 1 0 0 1",
                     done, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_stall_restart;
        logic [14:0] obs, expv;
        logic [3:0]  pat;
        int n;
        int cyc;
        pat = 4'b1001;
        n = 0;
        cyc = 0;
        out_ready = 1'b0;
        pulse_start();
        while (n < RUN && cyc < 200) begin
            obs  = {out_valid, out_x, out_y, out_idx, out_last, out_epoch};
            expv = {1'b1, exp_xa[n % 3], exp_ya[n % 3], 2'(n % 3), (n % 3) == 2, 2'(n / 3)};
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL stall[cyc %0d n %0d] got %h required %h", cyc, n, obs, expv);
            end
            out_ready = pat[cyc % 4];
            tick();
            if (out_ready) n++;
            cyc++;
        end
        tests++;
        if (n != RUN || done !== 1'b1) begin
            fails++;
            $display("FAIL stall_done transfers=%0d done=%b required %0d 1", n, done, RUN);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reload;
        logic [14:0] obs, expv;
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h86);
        send_byte(8'h00);
        send_byte(8'h83);
        tests++;
        if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reload_full in_ready=%b done=%b busy=%b required 0 0 0", in_ready, done, busy);
        end
        out_ready = 1'b1;
        pulse_start();
        for (int n = 0; n < RUN; n++) begin
            obs  = {out_valid, out_x, out_y, out_idx, out_last, out_epoch};
            expv = {1'b1, exp_xb[n % 3], exp_yb[n % 3], 2'(n % 3), (n % 3) == 2, 2'(n / 3)};
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL reload[%0d] got %h required %h", n, obs, expv);
            end
            tick();
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL reload_done done=%b required 1", done);
        end
    endtask

    task automatic test_reset_mid;
        logic [14:0] obs;
        int k;
        k = (EP > 1) ? 4 : 1;
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < k; i++) tick();
        tests++;
        if (out_idx !== 2'd1 || out_epoch !== 2'((EP > 1) ? 1 : 0) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_position idx=%0d ep=%0d valid=%b", out_idx, out_epoch, out_valid);
        end
        rst = 1'b1;
        #1;
        obs = {in_ready, out_valid, out_x, out_y, out_idx, out_last};
        tests++;
        if (obs !== 15'h0000 || out_epoch !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got %h ep=%0d busy=%b done=%b err=%b required all zero",
                     obs, out_epoch, busy, done, load_err);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle in_ready=%b busy=%b valid=%b required 1 0 0", in_ready, busy, out_valid);
        end
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h85);
        send_byte(8'h01);
        send_byte(8'h82);
        pulse_start();
        tests++;
        if (out_valid !== 1'b1 || out_x !== 8'h32 || out_y !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_stream valid=%b x=%h y=%b err=%b required 1 32 0 0",
                     out_valid, out_x, out_y, load_err);
        end
        for (int i = 0; i < RUN; i++) tick();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_done done=%b required 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_load_err();
        test_stream();
        test_stall_restart();
        test_reload();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
